hs_burst_source: RTL and testbench

// Transmitter end of the valid/ready stream protocol used by the pipeline nodes.
// - Accepts a burst command on a valid/ready command port.
// - Emits LEN data beats downstream, with an incrementing pattern starting at SEED.
// - Optionally inserts an idle gap between beats.
// - Feeds node chains in bring-up and test, and acts as the master side of the handshake.

---
 rtl/hs_burst_source.sv | 151 +++++++++++++++
 tb/tb_hs_burst_source.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_burst_source.sv
// Burst source: accepts a (len, seed, gap) command and emits len incrementing beats
// on a registered valid/ready stream, with optional idle cycles between beats.
module hs_burst_source #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid_in,
    output logic             cmd_ready_out,
    input  logic [LEN_W-1:0] cmd_len_in,
    input  logic [WIDTH-1:0] cmd_seed_in,
    input  logic [GAP_W-1:0] cmd_gap_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_down_out,
    output logic             last_out,
    input  logic             ready_down_in,
    output logic             busy_out,
    output logic             done_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gapCount_q, gapCount_d;

    logic cmdFire;
    logic downFire;

    assign cmd_ready_out  = (state_q == IDLE);
    assign busy_out       = (state_q != IDLE);
    assign cmdFire        = cmd_valid_in & cmd_ready_out;
    assign downFire       = valid_q & ready_down_in;

    assign data_out       = data_q;
    assign valid_down_out = valid_q;
    assign last_out       = last_q;
    assign done_out       = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
            gap_q       <= '0;
            gapCount_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            done_q      <= done_d;
            remaining_q <= remaining_d;
            gap_q       <= gap_d;
            gapCount_q  <= gapCount_d;
        end
    end

    // remaining_q counts the beat currently presented, so 1 means "this is the last one"
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmdFire && (cmd_len_in != '0)) state_d = SEND;
            end
            SEND: begin
                if (downFire) begin
                    if (remaining_q == LEN_W'(1)) state_d = IDLE;
                    else if (gap_q != '0)         state_d = GAP;
                end
            end
            GAP: begin
                if (gapCount_q == GAP_W'(1)) state_d = SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        done_d      = 1'b0;
        remaining_d = remaining_q;
        gap_d       = gap_q;
        gapCount_d  = gapCount_q;
        case (state_q)
            IDLE: begin
                if (cmdFire) begin
                    if (cmd_len_in != '0) begin
                        data_d      = cmd_seed_in;
                        valid_d     = 1'b1;
                        last_d      = (cmd_len_in == LEN_W'(1));
                        remaining_d = cmd_len_in;
                        gap_d       = cmd_gap_in;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (downFire) begin
                    if (remaining_q == LEN_W'(1)) begin
                        valid_d     = 1'b0;
                        last_d      = 1'b0;
                        done_d      = 1'b1;
                        remaining_d = '0;
                    end else begin
                        data_d      = data_q + WIDTH'(1);
                        remaining_d = remaining_q - LEN_W'(1);
                        last_d      = (remaining_q == LEN_W'(2));
                        if (gap_q != '0) begin
                            valid_d    = 1'b0;
                            last_d     = 1'b0;
                            gapCount_d = gap_q;
                        end
                    end
                end
            end
            GAP: begin
                // last is re-derived on the way out so it is only ever set alongside valid
                if (gapCount_q == GAP_W'(1)) begin
                    valid_d    = 1'b1;
                    last_d     = (remaining_q == LEN_W'(1));
                    gapCount_d = '0;
                end else begin
                    gapCount_d = gapCount_q - GAP_W'(1);
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hs_burst_source.sv
// Directed and randomized bursts checked against a beat-list model of the
// command: beat i carries seed+i, followed by gap idle cycles unless it is the last.
module tb_hs_burst_source;

    localparam int WIDTH = 32;
    localparam int LEN_W = 8;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid_in;
    logic             cmd_ready_out;
    logic [LEN_W-1:0] cmd_len_in;
    logic [WIDTH-1:0] cmd_seed_in;
    logic [GAP_W-1:0] cmd_gap_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_down_out;
    logic             last_out;
    logic             ready_down_in;
    logic             busy_out;
    logic             done_out;

    int checks = 0;
    int errors = 0;

    hs_burst_source #(.WIDTH(WIDTH), .LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid_in   (cmd_valid_in),
        .cmd_ready_out  (cmd_ready_out),
        .cmd_len_in     (cmd_len_in),
        .cmd_seed_in    (cmd_seed_in),
        .cmd_gap_in     (cmd_gap_in),
        .data_out       (data_out),
        .valid_down_out (valid_down_out),
        .last_out       (last_out),
        .ready_down_in  (ready_down_in),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Outputs are sampled and inputs driven 1 time unit after each rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkVal({tag, "_valid"}, 64'(valid_down_out), 64'(0));
        checkVal({tag, "_done"}, 64'(done_out), 64'(0));
        checkVal({tag, "_cmd_ready"}, 64'(cmd_ready_out), 64'(1));
        checkVal({tag, "_busy"}, 64'(busy_out), 64'(0));
    endtask

    // Random command traffic offered while the source is busy must have no effect
    task automatic garbage();
        cmd_valid_in = 1'($urandom_range(0, 1));
        cmd_len_in   = LEN_W'($urandom);
        cmd_seed_in  = $urandom;
        cmd_gap_in   = GAP_W'($urandom);
    endtask

    // Issues one command at the current (idle) sample point and follows the whole burst
    // through to its done cycle; returns at the done cycle with cmd_valid_in low.
    task automatic runBurst(input int len, input logic [WIDTH-1:0] seed, input int gap,
                            input int stallPct, input int stallBeat, input int stallCycles);
        int   stalls;
        logic r;
        logic [WIDTH-1:0] expData;
        checkVal("accept_cmd_ready", 64'(cmd_ready_out), 64'(1));
        cmd_valid_in  = 1'b1;
        cmd_len_in    = LEN_W'(len);
        cmd_seed_in   = seed;
        cmd_gap_in    = GAP_W'(gap);
        ready_down_in = 1'($urandom_range(0, 1));
        step();
        cmd_valid_in = 1'b0;
        if (len == 0) begin
            checkVal("len0_done", 64'(done_out), 64'(1));
            checkVal("len0_valid", 64'(valid_down_out), 64'(0));
            checkVal("len0_cmd_ready", 64'(cmd_ready_out), 64'(1));
            checkVal("len0_busy", 64'(busy_out), 64'(0));
            return;
        end
        for (int i = 0; i < len; i++) begin
            expData = seed + WIDTH'(i);
            stalls  = 0;
            do begin
                checkVal($sformatf("beat%0d_valid", i), 64'(valid_down_out), 64'(1));
                checkVal($sformatf("beat%0d_data", i), 64'(data_out), 64'(expData));
                checkVal($sformatf("beat%0d_last", i), 64'(last_out), 64'(i == len - 1));
                checkVal($sformatf("beat%0d_done", i), 64'(done_out), 64'(0));
                checkVal($sformatf("beat%0d_busy", i), 64'(busy_out), 64'(1));
                checkVal($sformatf("beat%0d_cmd_ready", i), 64'(cmd_ready_out), 64'(0));
                if (i == stallBeat) r = (stalls >= stallCycles);
                else r = (stalls >= 4) || (int'($urandom_range(0, 99)) >= stallPct);
                ready_down_in = r;
                garbage();
                step();
                stalls++;
            end while (!r);
            if (i < len - 1) begin
                for (int g = 0; g < gap; g++) begin
                    checkVal($sformatf("gap%0d_%0d_valid", i, g), 64'(valid_down_out), 64'(0));
                    checkVal($sformatf("gap%0d_%0d_busy", i, g), 64'(busy_out), 64'(1));
                    checkVal($sformatf("gap%0d_%0d_done", i, g), 64'(done_out), 64'(0));
                    ready_down_in = 1'($urandom_range(0, 1));
                    garbage();
                    step();
                end
            end
        end
        cmd_valid_in  = 1'b0;
        ready_down_in = 1'b0;
        checkVal("end_done", 64'(done_out), 64'(1));
        checkVal("end_valid", 64'(valid_down_out), 64'(0));
        checkVal("end_last", 64'(last_out), 64'(0));
        checkVal("end_busy", 64'(busy_out), 64'(0));
        checkVal("end_cmd_ready", 64'(cmd_ready_out), 64'(1));
    endtask

    initial begin
        rst           = 1'b1;
        cmd_valid_in  = 1'b0;
        cmd_len_in    = '0;
        cmd_seed_in   = '0;
        cmd_gap_in    = '0;
        ready_down_in = 1'b0;
        step();
        step();
        checkIdle("por");
        checkVal("por_data", 64'(data_out), 64'(0));
        checkVal("por_last", 64'(last_out), 64'(0));
        rst = 1'b0;
        step();
        checkIdle("por_release");

        $display("[TB] T2 back-to-back burst");
        runBurst(4, 32'h10, 0, 0, -1, 0);
        step();
        checkIdle("t2_after_done");

        $display("[TB] T3 stalled beat");
        runBurst(4, 32'h10, 0, 0, 1, 3);
        step();
        checkIdle("t3_after_done");

        $display("[TB] T4 gapped burst");
        runBurst(3, 32'h0, 2, 0, -1, 0);
        step();
        checkIdle("t4_after_done");

        $display("[TB] T5 data wrap");
        runBurst(2, 32'hFFFF_FFFF, 0, 0, -1, 0);
        step();

        $display("[TB] T6 zero-length command, then accept in the done cycle");
        runBurst(0, 32'h55, 0, 0, -1, 0);
        runBurst(2, 32'hA0, 1, 30, -1, 0);
        runBurst(3, 32'hB0, 0, 30, -1, 0);
        step();
        checkIdle("t6_after_chain");

        $display("[TB] T1 reset mid-activity");
        cmd_valid_in = 1'b1;
        cmd_len_in   = LEN_W'(6);
        cmd_seed_in  = 32'h77;
        cmd_gap_in   = GAP_W'(1);
        step();
        ready_down_in = 1'b1;
        step();
        rst = 1'b1;
        step();
        checkIdle("t1_reset1");
        checkVal("t1_reset1_data", 64'(data_out), 64'(0));
        step();
        checkIdle("t1_reset2");
        checkVal("t1_reset2_data", 64'(data_out), 64'(0));
        checkVal("t1_reset2_last", 64'(last_out), 64'(0));
        rst           = 1'b0;
        cmd_valid_in  = 1'b0;
        ready_down_in = 1'b0;
        step();
        checkIdle("t1_release");

        $display("[TB] T6 reset during beat 2 of 5");
        cmd_valid_in = 1'b1;
        cmd_len_in   = LEN_W'(5);
        cmd_seed_in  = 32'h100;
        cmd_gap_in   = GAP_W'(0);
        step();
        cmd_valid_in  = 1'b0;
        ready_down_in = 1'b1;
        checkVal("abort_beat0", 64'(data_out), 64'(32'h100));
        step();
        checkVal("abort_beat1", 64'(data_out), 64'(32'h101));
        step();
        checkVal("abort_beat2", 64'(data_out), 64'(32'h102));
        checkVal("abort_beat2_valid", 64'(valid_down_out), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        ready_down_in = 1'b0;
        checkIdle("abort_after");
        checkVal("abort_after_data", 64'(data_out), 64'(0));
        runBurst(3, 32'h200, 1, 20, -1, 0);
        step();
        checkIdle("abort_recover");

        $display("[TB] long burst with wrap");
        runBurst(255, 32'hFFFF_FF80, 0, 10, -1, 0);
        step();

        $display("[TB] randomized bursts");
        for (int n = 0; n < 30; n++) begin
            int len;
            int gap;
            len = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 7));
            gap = int'($urandom_range(0, 3));
            runBurst(len, $urandom, gap, 35, -1, 0);
            if ($urandom_range(0, 1) == 1) begin
                step();
                checkIdle($sformatf("rand%0d_idle", n));
            end
        end

        step();
        checkIdle("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
